game_tick_scheduler: RTL and testbench

Sequencing and configuration controller for the game-speed frequency divider. It owns the divider's `DIVISOR` input and its active-low reset. It turns divider output toggles into single-cycle `game_tick` strobes for the snake movement logic. It raises speed on each food event and handles start, pause and game-over, so the divisor never changes while the divider's counter is running.

---
 rtl/snake_timing_pkg.sv | 38 +++
 rtl/tick_edge_detect.sv | 32 +++
 rtl/game_tick_scheduler.sv | 147 ++++++++++++++
 tb/tb_game_tick_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_timing_pkg
//  Brief    : Shared state encoding, divisor type and default divisor constants
//             for the snake game-speed scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package snake_timing_pkg;

    typedef logic [24:0] div_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RELOAD = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam div_t       DEF_BASE_DIV  = 25'd12_500_000;
    localparam div_t       DEF_STEP_DIV  = 25'd1_000_000;
    localparam div_t       DEF_MIN_DIV   = 25'd2_500_000;
    localparam logic [3:0] DEF_MAX_LEVEL = 4'd10;

    // max(base - lvl*step, floor) with a signed difference so underflow clamps
    function automatic div_t calc_divisor(input logic [3:0] lvl, input div_t base,
                                          input div_t step, input div_t floor_div);
        logic [28:0]        prod;
        logic signed [30:0] diff;
        prod = 29'(lvl) * 29'(step);
        diff = $signed({6'b0, base}) - $signed({2'b0, prod});
        if (diff < $signed({6'b0, floor_div}))
            return floor_div;
        return div_t'(diff);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tick_edge_detect
//  Brief    : Turns any change of the divider output into a registered
//             one-cycle tick; suppress forces the history to 0 and masks ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic div_clk,
    input  logic suppress,
    output logic game_tick
);

    logic div_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_prev  <= 1'b0;
            game_tick <= 1'b0;
        end else if (suppress) begin
            div_prev  <= 1'b0;
            game_tick <= 1'b0;
        end else begin
            div_prev  <= div_clk;
            game_tick <= div_clk ^ div_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : game_tick_scheduler
//  Brief    : Owns the game-speed divider's DIVISOR and reset, sequences
//             start/pause/speed-up/game-over and emits movement ticks.
//             Optional GAME_TICK_BOOST_EN adds a boost input halving the divisor.
//  Revision : 1.0 - initial release
// ============================================================================
module game_tick_scheduler
    import snake_timing_pkg::*;
#(
    parameter div_t       BASE_DIV  = DEF_BASE_DIV,
    parameter div_t       STEP_DIV  = DEF_STEP_DIV,
    parameter div_t       MIN_DIV   = DEF_MIN_DIV,
    parameter logic [3:0] MAX_LEVEL = DEF_MAX_LEVEL
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        start,
    input  logic        speed_up,
    input  logic        pause_tgl,
    input  logic        game_over,
    input  logic        div_clk,
`ifdef GAME_TICK_BOOST_EN
    input  logic        boost,
`endif
    output logic [24:0] divisor,
    output logic        div_rst,
    output logic        game_tick,
    output logic [3:0]  level,
    output logic        paused
);

    state_e     state;
    state_e     state_nxt;
    logic       pending;
    logic       pending_nxt;
    logic [3:0] level_nxt;
    logic       reload_d;
    logic       leave_run;
    logic       can_speed;
    div_t       calc_div;
    div_t       reload_div;

    assign can_speed = (level < MAX_LEVEL);
    assign calc_div  = calc_divisor(level_nxt, BASE_DIV, STEP_DIV, MIN_DIV);

`ifdef GAME_TICK_BOOST_EN
    logic boost_prev;

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) boost_prev <= 1'b0;
        else      boost_prev <= boost;
    end

    assign reload_div = boost ? (calc_div >> 1) : calc_div;
`else
    assign reload_div = calc_div;
`endif

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        level_nxt   = level;
        leave_run   = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start && !game_over) begin
                    level_nxt   = 4'd0;
                    pending_nxt = 1'b0;
                    state_nxt   = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                pending_nxt = 1'b0;
                state_nxt   = game_over ? ST_OVER : ST_RUN;
            end
            ST_RUN: begin
                if (game_over) begin
                    state_nxt   = ST_OVER;
                    pending_nxt = 1'b0;
                    leave_run   = 1'b1;
                end else if (pause_tgl) begin
                    state_nxt   = ST_PAUSE;
                    leave_run   = 1'b1;
                end else begin
                    if (speed_up && can_speed) begin
                        level_nxt   = level + 4'd1;
                        pending_nxt = 1'b1;
                    end
`ifdef GAME_TICK_BOOST_EN
                    if (boost != boost_prev) pending_nxt = 1'b1;
`endif
                    // reload only right after a tick so the tick cadence is never cut short
                    if (game_tick && pending_nxt) begin
                        state_nxt   = ST_RELOAD;
                        pending_nxt = 1'b0;
                    end
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_nxt   = ST_OVER;
                    pending_nxt = 1'b0;
                end else if (pause_tgl) begin
                    state_nxt   = ST_RELOAD;
                    pending_nxt = 1'b0;
                end else if (speed_up && can_speed) begin
                    level_nxt   = level + 4'd1;
                    pending_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // divisor is loaded on entry to RELOAD so it only moves while div_rst is low
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            divisor  <= BASE_DIV;
            div_rst  <= 1'b0;
            level    <= 4'd0;
            paused   <= 1'b0;
            pending  <= 1'b0;
            reload_d <= 1'b0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            pending  <= pending_nxt;
            div_rst  <= (state_nxt == ST_RUN);
            paused   <= (state_nxt == ST_PAUSE);
            reload_d <= (state == ST_RELOAD);
            if (state_nxt == ST_RELOAD) divisor <= reload_div;
        end
    end

    tick_edge_detect u_edge (
        .clk       (clk_50M),
        .rst       (rst),
        .div_clk   (div_clk),
        .suppress  ((state != ST_RUN) || reload_d || leave_run),
        .game_tick (game_tick)
    );

endmodule
`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_tick_scheduler
//  Brief    : Directed bench with an attached divider and a cycle-schedule
//             model of the scheduler's outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_tick_scheduler;

    localparam logic [24:0] P_BASE = 25'd10;
    localparam logic [24:0] P_STEP = 25'd2;
    localparam logic [24:0] P_MIN  = 25'd4;
    localparam logic [3:0]  P_MAX  = 4'd4;
    localparam int M_IDLE = 0, M_RELOAD = 1, M_RUN = 2, M_PAUSE = 3, M_OVER = 4;

    logic        clk_50M = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, speed_up = 1'b0, pause_tgl = 1'b0, game_over = 1'b0;
    logic        div_clk;
    logic [24:0] divisor;
    logic        div_rst, game_tick, paused;
    logic [3:0]  level;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    game_tick_scheduler #(
        .BASE_DIV (P_BASE),
        .STEP_DIV (P_STEP),
        .MIN_DIV  (P_MIN),
        .MAX_LEVEL(P_MAX)
    ) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .start    (start),
        .speed_up (speed_up),
        .pause_tgl(pause_tgl),
        .game_over(game_over),
        .div_clk  (div_clk),
`ifdef GAME_TICK_BOOST_EN
        .boost    (1'b0),
`endif
        .divisor  (divisor),
        .div_rst  (div_rst),
        .game_tick(game_tick),
        .level    (level),
        .paused   (paused)
    );

    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // Frequency divider: clk_out toggles every DIVISOR cycles, cleared while held in reset
    logic [24:0] dcnt;
    always_ff @(posedge clk_50M or negedge div_rst) begin
        if (!div_rst) begin
            dcnt    <= '0;
            div_clk <= 1'b0;
        end else if (dcnt == divisor - 25'd1) begin
            dcnt    <= '0;
            div_clk <= ~div_clk;
        end else begin
            dcnt <= dcnt + 25'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_div(input int lvl);
        int d;
        d = int'(P_BASE) - lvl * int'(P_STEP);
        return (d < int'(P_MIN)) ? int'(P_MIN) : d;
    endfunction

    // Model: game mode plus an absolute cycle number for the next expected tick
    int m_st, m_level, m_div, m_next, m_old;
    bit m_pend, m_tick, m_told;

    always @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            m_st = M_IDLE; m_level = 0; m_pend = 0; m_div = int'(P_BASE);
            m_tick = 0; m_next = 0;
        end else begin
            m_old  = m_st;
            m_told = m_tick;
            m_tick = 0;
            case (m_old)
                M_IDLE, M_OVER: begin
                    if (start && !game_over) begin
                        m_level = 0; m_pend = 0; m_st = M_RELOAD; m_div = exp_div(0);
                    end
                end
                M_RELOAD: begin
                    if (game_over) m_st = M_OVER;
                    else begin
                        m_st   = M_RUN;
                        m_next = cyc + 1 + m_div + 1;
                    end
                end
                M_RUN: begin
                    if (game_over) begin
                        m_st = M_OVER; m_pend = 0;
                    end else if (pause_tgl) begin
                        m_st = M_PAUSE;
                    end else begin
                        if (speed_up && m_level < int'(P_MAX)) begin
                            m_level++; m_pend = 1;
                        end
                        if (m_told && m_pend) begin
                            m_st = M_RELOAD; m_pend = 0; m_div = exp_div(m_level);
                        end else if (cyc + 1 == m_next) begin
                            m_tick = 1;
                            m_next = m_next + m_div;
                        end
                    end
                end
                M_PAUSE: begin
                    if (game_over) begin
                        m_st = M_OVER; m_pend = 0;
                    end else if (pause_tgl) begin
                        m_st = M_RELOAD; m_pend = 0; m_div = exp_div(m_level);
                    end else if (speed_up && m_level < int'(P_MAX)) begin
                        m_level++; m_pend = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    bit          chk_en = 0;
    logic [24:0] prev_div;

    always @(negedge clk_50M) begin
        if (chk_en) begin
            check("game_tick", 32'(game_tick), 32'(m_tick));
            check("div_rst",   32'(div_rst),   32'(m_st == M_RUN));
            check("paused",    32'(paused),    32'(m_st == M_PAUSE));
            check("level",     32'(level),     m_level);
            check("divisor",   32'(divisor),   m_div);
            if (divisor !== prev_div) check("divisor_moved_with_div_rst_high", 32'(div_rst), 0);
            prev_div = divisor;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic pulse(input logic s, input logic su, input logic pt, input logic go);
        start = s; speed_up = su; pause_tgl = pt; game_over = go;
        @(negedge clk_50M);
        start = 1'b0; speed_up = 1'b0; pause_tgl = 1'b0; game_over = 1'b0;
    endtask

    task automatic wait_tick(input string name, output int t);
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_50M);
            if (game_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no game_tick within 64 cycles (cycle %0d)", name, cyc);
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk_50M);
            if (game_tick === 1'b1) cnt++;
        end
    endtask

    initial begin
        int s, t1, t2, t3, t4, n;
        #2 rst = 1'b0;
        cycles(3);
        check("rst_divisor",   32'(divisor),   10);
        check("rst_div_rst",   32'(div_rst),   0);
        check("rst_game_tick", 32'(game_tick), 0);
        check("rst_level",     32'(level),     0);
        check("rst_paused",    32'(paused),    0);
        rst = 1'b1; prev_div = divisor; chk_en = 1;
        cycles(2);

        // start: RELOAD, release, then ticks every 10
        s = cyc; pulse(1, 0, 0, 0);
        wait_tick("first_tick", t1);
        check("first_tick_latency", t1 - s, 13);
        wait_tick("tick2", t2);
        check("period_lvl0", t2 - t1, 10);

        // speed_up coinciding with a tick: reload on the next cycle
        pulse(0, 1, 0, 0);
        check("lvl1_level",   32'(level),   1);
        check("lvl1_divisor", 32'(divisor), 8);
        check("lvl1_reload_div_rst", 32'(div_rst), 0);
        wait_tick("tick3", t3);
        check("lvl1_first_tick", t3 - t2, 11);
        wait_tick("tick4", t4);
        check("period_lvl1", t4 - t3, 8);

        // pause, idle, speed_up while paused, resume
        cycles(3);
        pulse(0, 0, 1, 0);
        check("pause_paused",  32'(paused),  1);
        check("pause_div_rst", 32'(div_rst), 0);
        count_ticks(50, n);
        check("pause_no_ticks", n, 0);
        pulse(0, 1, 0, 0);
        check("pause_level",   32'(level),   2);
        check("pause_divisor", 32'(divisor), 8);
        s = cyc; pulse(0, 0, 1, 0);
        check("resume_divisor", 32'(divisor), 6);
        check("resume_paused",  32'(paused),  0);
        wait_tick("resume_tick", t1);
        check("resume_first_tick", t1 - s, 9);
        wait_tick("resume_tick2", t2);
        check("period_lvl2", t2 - t1, 6);

        // speed_up mid-period: pending until the next tick
        cycles(3);
        pulse(0, 1, 0, 0);
        check("pend_level",   32'(level),   3);
        check("pend_divisor", 32'(divisor), 6);
        wait_tick("pend_tick", t3);
        check("pend_old_period", t3 - t2, 6);
        cycles(1);
        check("lvl3_divisor", 32'(divisor), 4);
        wait_tick("lvl3_tick", t4);
        check("lvl3_first_tick", t4 - t3, 7);

        // saturation: level caps at 4, divisor clamps to MIN_DIV
        repeat (6) begin
            pulse(0, 1, 0, 0);
            cycles(1);
        end
        check("sat_level", 32'(level), 4);
        cycles(20);
        wait_tick("sat_tick", t1);
        wait_tick("sat_tick2", t2);
        check("period_sat", t2 - t1, 4);
        check("sat_divisor", 32'(divisor), 4);

        // game_over wins over start; level held for score display
        pulse(1, 0, 0, 1);
        check("over_div_rst", 32'(div_rst), 0);
        check("over_level",   32'(level),   4);
        count_ticks(20, n);
        check("over_no_ticks", n, 0);
        s = cyc; pulse(1, 0, 0, 0);
        check("restart_level",   32'(level),   0);
        check("restart_divisor", 32'(divisor), 10);
        wait_tick("restart_tick", t1);
        check("restart_first_tick", t1 - s, 13);
        wait_tick("restart_tick2", t2);
        check("restart_period", t2 - t1, 10);

        // async reset in the middle of a RELOAD cycle
        pulse(0, 1, 0, 0);
        check("pre_rst_divisor", 32'(divisor), 8);
        #2 rst = 1'b0;
        #1;
        check("arst_divisor",   32'(divisor),   10);
        check("arst_level",     32'(level),     0);
        check("arst_div_rst",   32'(div_rst),   0);
        check("arst_game_tick", 32'(game_tick), 0);
        check("arst_paused",    32'(paused),    0);
        cycles(3);
        rst = 1'b1;
        count_ticks(30, n);
        check("post_rst_no_ticks", n, 0);
        check("post_rst_div_rst", 32'(div_rst), 0);
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
